// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the local-port injection arbiter: flit width,
// counter width default and the two-state arbiter encoding.
package noc_inject_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int ARB_CNT_W      = 16;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Flit handshake bundle between the local sources, the injection arbiter and
// the router local port. The slave view belongs to the arbiter.
interface noc_inject_arbiter_if
    import noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = NOC_DATA_WIDTH
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_is_header;
    logic [NUM_REQ-1:0]        req_is_tail;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_flit;
    logic                      out_is_header;
    logic                      out_is_tail;

    modport master (
        output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
        input  req_ready, out_valid, out_flit, out_is_header, out_is_tail
    );

    modport slave (
        input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
        output req_ready, out_valid, out_flit, out_is_header, out_is_tail
    );

endinterface

// File: rtl/noc_rr_pick.sv
// Combinational round-robin finder: first set bit of req_mask searching from
// rr_ptr upward, wrapping modulo NUM_REQ.
module noc_rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_mask,
    input  logic [REQ_IDX_W-1:0] rr_ptr,
    output logic                 found,
    output logic [REQ_IDX_W-1:0] idx
);

    int pos_s;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = {REQ_IDX_W{1'b0}};
        pos_s = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos_s = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_mask[pos_s]) begin
                found = 1'b1;
                idx   = REQ_IDX_W'(pos_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter for the router local injection port. A
// header takes the grant, the tail transfer releases it; packets never interleave.
module noc_inject_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = $clog2(NUM_REQ),
    parameter int CNT_W     = ARB_CNT_W
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst,
    noc_inject_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 proto_err
);

    localparam int W = NOC_DATA_WIDTH;

    arb_state_e           state_r;
    logic [REQ_IDX_W-1:0] gnt_idx_r;
    logic [REQ_IDX_W-1:0] rr_ptr_r;
    logic                 first_r;
    logic [CNT_W-1:0]     pkt_count_r;
    logic                 proto_err_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 busy_r;

    logic [NUM_REQ-1:0]   eligible_s;
    logic                 pick_found_s;
    logic [REQ_IDX_W-1:0] pick_idx_s;
    logic [REQ_IDX_W-1:0] next_ptr_s;
    logic                 xfer_s;

    assign eligible_s = bus.req_valid & bus.req_is_header;

    noc_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_pick (
        .req_mask (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    assign next_ptr_s = (gnt_idx_r == REQ_IDX_W'(NUM_REQ - 1)) ? {REQ_IDX_W{1'b0}}
                                                               : gnt_idx_r + REQ_IDX_W'(1);

    // Datapath mux: owner's flit passes straight through while LOCKED.
    always_comb begin
        bus.out_valid     = 1'b0;
        bus.out_flit      = {W{1'b0}};
        bus.out_is_header = 1'b0;
        bus.out_is_tail   = 1'b0;
        bus.req_ready     = {NUM_REQ{1'b0}};
        if (state_r == ARB_LOCKED) begin
            bus.out_valid            = bus.req_valid[gnt_idx_r];
            bus.out_flit             = bus.req_flit[int'(gnt_idx_r)*W +: W];
            bus.out_is_header        = bus.req_is_header[gnt_idx_r];
            bus.out_is_tail          = bus.req_is_tail[gnt_idx_r];
            bus.req_ready[gnt_idx_r] = bus.out_ready;
        end else begin
            bus.req_ready = {NUM_REQ{1'b0}};
        end
    end

    assign xfer_s = bus.out_valid & bus.out_ready;

    // Arbiter FSM with registered status outputs.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_r     <= ARB_IDLE;
            gnt_idx_r   <= {REQ_IDX_W{1'b0}};
            rr_ptr_r    <= {REQ_IDX_W{1'b0}};
            first_r     <= 1'b0;
            pkt_count_r <= {CNT_W{1'b0}};
            proto_err_r <= 1'b0;
            grant_r     <= {NUM_REQ{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_found_s) begin
                        state_r   <= ARB_LOCKED;
                        gnt_idx_r <= pick_idx_s;
                        first_r   <= 1'b1;
                        grant_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ARB_IDLE;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_s) begin
                        first_r <= 1'b0;
                        // A second header inside one packet is flagged but still forwarded.
                        if (bus.out_is_header && !first_r) begin
                            proto_err_r <= 1'b1;
                        end else begin
                            proto_err_r <= proto_err_r;
                        end
                        if (bus.out_is_tail) begin
                            state_r     <= ARB_IDLE;
                            rr_ptr_r    <= next_ptr_s;
                            pkt_count_r <= pkt_count_r + CNT_W'(1);
                            grant_r     <= {NUM_REQ{1'b0}};
                            busy_r      <= 1'b0;
                        end else begin
                            state_r     <= ARB_LOCKED;
                        end
                    end else begin
                        state_r <= ARB_LOCKED;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    grant_r <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_onehot = grant_r;
    assign busy         = busy_r;
    assign pkt_count    = pkt_count_r;
    assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: per-requester flit sources, a log of
// out-port transfers, and hand-computed expectations.
module tb_noc_inject_arbiter;
    import noc_inject_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int W  = NOC_DATA_WIDTH;

    logic          noc_clk = 1'b0;
    logic          noc_rst = 1'b1;
    logic          rst4    = 1'b1;
    logic [NR-1:0] grant_onehot, grant4;
    logic          busy, busy4;
    logic [15:0]   pkt_count;
    logic [3:0]    pkt4;
    logic          proto_err, perr4;

    noc_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(W)) bus ();
    noc_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(W)) bus4 ();

    noc_inject_arbiter #(.NUM_REQ(NR), .CNT_W(16)) dut (
        .noc_clk (noc_clk), .noc_rst (noc_rst), .bus (bus.slave),
        .grant_onehot (grant_onehot), .busy (busy),
        .pkt_count (pkt_count), .proto_err (proto_err)
    );

    noc_inject_arbiter #(.NUM_REQ(NR), .CNT_W(4)) dut4 (
        .noc_clk (noc_clk), .noc_rst (rst4), .bus (bus4.slave),
        .grant_onehot (grant4), .busy (busy4),
        .pkt_count (pkt4), .proto_err (perr4)
    );

    always #5 noc_clk = ~noc_clk;

    logic [W-1:0] src_flit [NR][8];
    logic [7:0]   src_h [NR];
    logic [7:0]   src_t [NR];
    int           src_n [NR];
    int           src_p [NR];
    logic [W-1:0] xq [$];
    logic [NR-1:0] acc;
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int r, input int k);
        return {24'hA5A5A5, 4'(r), 4'(k)};
    endfunction

    task automatic load(input int r, input int n, input logic [7:0] h, input logic [7:0] t);
        for (int k = 0; k < n; k++) src_flit[r][k] = mk(r, k);
        src_n[r] = n;
        src_p[r] = 0;
        src_h[r] = h;
        src_t[r] = t;
    endtask

    task automatic clear_src();
        for (int r = 0; r < NR; r++) begin
            src_n[r] = 0;
            src_p[r] = 0;
            src_h[r] = 8'h00;
            src_t[r] = 8'h00;
        end
    endtask

    task automatic drive();
        logic [NR-1:0]   v, h, t;
        logic [NR*W-1:0] f;
        v = '0; h = '0; t = '0; f = '0;
        for (int r = 0; r < NR; r++) begin
            if (src_p[r] < src_n[r]) begin
                v[r]         = 1'b1;
                f[r*W +: W]  = src_flit[r][src_p[r]];
                h[r]         = src_h[r][src_p[r]];
                t[r]         = src_t[r][src_p[r]];
            end
        end
        bus.req_valid     = v;
        bus.req_flit      = f;
        bus.req_is_header = h;
        bus.req_is_tail   = t;
        #1;
    endtask

    // Record pre-edge handshakes, advance one clock, then re-drive sources.
    task automatic tick();
        acc = bus.req_ready & bus.req_valid;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xq.push_back(bus.out_flit);
        @(posedge noc_clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (acc[r] === 1'b1) src_p[r]++;
        end
        drive();
    endtask

    task automatic reset_main();
        noc_rst = 1'b1;
        tick();
        clear_src();
        xq.delete();
        drive();
        noc_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.out_ready      = 1'b1;
        bus4.out_ready     = 1'b1;
        bus4.req_valid     = 4'b0001;
        bus4.req_is_header = 4'b0001;
        bus4.req_is_tail   = 4'b0001;
        bus4.req_flit      = {(NR*W){1'b0}};
        clear_src();
        drive();
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_grant", 64'(grant_onehot), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);

        // Single 3-flit packet from requester 2
        noc_rst = 1'b0;
        load(2, 3, 8'b001, 8'b100);
        drive();
        chk("t1_idle_grant", 64'(grant_onehot), 64'd0);
        chk("t1_idle_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t1_grant", 64'(grant_onehot), 64'h4);
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_flit", 64'(bus.out_flit), 64'(mk(2, 0)));
        chk("t1_out_hdr", 64'(bus.out_is_header), 64'd1);
        chk("t1_req_ready", 64'(bus.req_ready), 64'h4);
        tick(); tick(); tick();
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_grant_end", 64'(grant_onehot), 64'd0);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);
        chk("t1_xfers", 64'(xq.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t1_flit_%0d", i), 64'(xq[i]), 64'(mk(2, i)));

        // Pointer now at 3: single-flit packets on 0 and 3, 3 goes first
        load(0, 1, 8'b1, 8'b1);
        load(3, 1, 8'b1, 8'b1);
        drive();
        tick();
        chk("rr_first_grant", 64'(grant_onehot), 64'h8);
        tick();
        chk("sf_busy_after", 64'(busy), 64'd0);
        chk("sf_pkt_count", 64'(pkt_count), 64'd2);
        tick();
        chk("rr_second_grant", 64'(grant_onehot), 64'h1);
        tick();
        chk("sf_pkt_count2", 64'(pkt_count), 64'd3);
        chk("sf_proto_err", 64'(proto_err), 64'd0);
        chk("rr_flit_a", 64'(xq[3]), 64'(mk(3, 0)));
        chk("rr_flit_b", 64'(xq[4]), 64'(mk(0, 0)));

        // All four requesters contend from reset
        reset_main();
        for (int r = 0; r < NR; r++) load(r, 3, 8'b001, 8'b100);
        drive();
        chk("t2_pkt_reset", 64'(pkt_count), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            logic [NR-1:0] eg;
            tick();
            eg = ((k - 1) % 4 < 3) ? NR'(1 << ((k - 1) / 4)) : NR'(0);
            chk($sformatf("t2_grant_%0d", k), 64'(grant_onehot), 64'(eg));
        end
        chk("t2_pkt_count", 64'(pkt_count), 64'd4);
        chk("t2_xfers", 64'(xq.size()), 64'd12);
        for (int i = 0; i < 12; i++) chk($sformatf("t2_flit_%0d", i), 64'(xq[i]), 64'(mk(i / 3, i % 3)));

        // Back-pressure mid-packet on requester 1, requester 3 waits
        reset_main();
        load(1, 3, 8'b001, 8'b100);
        drive();
        tick();
        tick();
        bus.out_ready = 1'b0;
        load(3, 3, 8'b001, 8'b100);
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3_flit_%0d", k), 64'(bus.out_flit), 64'(mk(1, 1)));
            chk($sformatf("t3_ready_%0d", k), 64'(bus.req_ready), 64'd0);
            chk($sformatf("t3_grant_%0d", k), 64'(grant_onehot), 64'h2);
        end
        bus.out_ready = 1'b1;
        drive();
        tick();
        tick();
        chk("t3_released", 64'(grant_onehot), 64'd0);
        tick();
        chk("t3_next_grant", 64'(grant_onehot), 64'h8);
        chk("t3_xfers", 64'(xq.size()), 64'd3);
        chk("t3_last", 64'(xq[2]), 64'(mk(1, 2)));

        // Repeated header inside a packet
        reset_main();
        load(0, 4, 8'b0101, 8'b1000);
        drive();
        tick(); tick(); tick();
        chk("t5_perr_before", 64'(proto_err), 64'd0);
        tick();
        chk("t5_perr_set", 64'(proto_err), 64'd1);
        tick();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_pkt", 64'(pkt_count), 64'd1);
        chk("t5_perr_sticky", 64'(proto_err), 64'd1);
        chk("t5_xfers", 64'(xq.size()), 64'd4);
        chk("t5_hdr2_fwd", 64'(xq[2]), 64'(mk(0, 2)));

        // Reset in the middle of a packet
        load(1, 3, 8'b001, 8'b100);
        drive();
        tick();
        tick();
        chk("t5_locked", 64'(busy), 64'd1);
        noc_rst = 1'b1;
        tick();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_grant", 64'(grant_onehot), 64'd0);
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_out_flit", 64'(bus.out_flit), 64'd0);
        chk("mr_out_tail", 64'(bus.out_is_tail), 64'd0);
        chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mr_pkt", 64'(pkt_count), 64'd0);
        chk("mr_perr", 64'(proto_err), 64'd0);
        noc_rst = 1'b0;
        tick();
        chk("mr_nonhdr_ignored", 64'(grant_onehot), 64'd0);
        chk("mr_nonhdr_valid", 64'(bus.out_valid), 64'd0);

        // 4-bit counter wrap with 17 single-flit packets
        rst4 = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            @(posedge noc_clk);
            #1;
            if (i == 1)  chk("w_grant", 64'(grant4), 64'h1);
            if (i == 2)  chk("w_pkt_1", 64'(pkt4), 64'd1);
            if (i == 32) chk("w_pkt_16", 64'(pkt4), 64'd0);
            if (i == 34) chk("w_pkt_17", 64'(pkt4), 64'd1);
        end
        chk("w_perr", 64'(perr4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
